// File: rtl/fetch_prefetch_pkg.sv
// Shared definitions for the prefetching fetch unit.
// Holds the default PC step and reset PC, and the width helpers used to size
// the prefetch FIFO pointers and occupancy counter.
package fetch_prefetch_pkg;

  localparam int unsigned DefaultPcStep  = 4;
  localparam int unsigned DefaultResetPc = 0;

  // Read/write pointer width for a FIFO of the given depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy counter width; must be able to hold the value `depth` itself.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// Instruction stream from fetch to decode (valid/ready handshake).
//   inst_valid : head entry present
//   inst_ready : decode accepts the head this cycle
//   inst       : head instruction word
//   inst_PC    : address the head instruction was fetched from
// master = fetch side, slave = decode side.
interface fetch_prefetch_if #(
  parameter int unsigned ADDRESS_BITS = 16,
  parameter int unsigned DATA_WIDTH   = 32
);

  logic                    inst_valid;
  logic                    inst_ready;
  logic [DATA_WIDTH-1:0]   inst;
  logic [ADDRESS_BITS-1:0] inst_PC;

  modport master (
    output inst_valid,
    output inst,
    output inst_PC,
    input  inst_ready
  );

  modport slave (
    input  inst_valid,
    input  inst,
    input  inst_PC,
    output inst_ready
  );

endinterface

// File: rtl/fetch_prefetch_fifo.sv
// Synchronous FIFO buffering fetched {instruction, PC} entries.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   flush        : synchronous clear; wins over push and pop
//   push         : write push_data at the tail
//   push_data    : entry to write
//   pop          : drop the head entry (ignored when empty)
//   head_data    : current head, read from registered storage
//   count        : number of entries held
module fetch_prefetch_fifo
  import fetch_prefetch_pkg::*;
#(
  parameter int unsigned  WIDTH  = 48,
  parameter int unsigned  DEPTH  = 4,
  localparam int unsigned PtrW   = ptr_width(DEPTH),
  localparam int unsigned CountW = count_width(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  head_data,
  output logic [CountW-1:0] count
);

  localparam logic [CountW-1:0] DepthC = CountW'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop    = pop && (count_q != '0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push   = push && ((count_q != DepthC) || do_pop);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // Storage is cleared too so the head reads as zero out of reset.
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch unit with a prefetch queue.
// Owns the PC, issues sequential reads to a synchronous instruction memory
// (data returns one cycle after the request) and buffers returned
// instructions with their PCs for decode.
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   next_PC_select : redirect strobe; flushes queue and in-flight read
//   target_PC      : redirect address, used unmodified
//   imem_req       : read request this cycle
//   imem_addr      : read address (equals PC)
//   imem_rdata     : read data, one cycle after imem_req
//   dec            : instruction stream to decode (master side)
//   PC             : next fetch address
//   count          : entries currently queued
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int unsigned  ADDRESS_BITS = 16,
  parameter int unsigned  DATA_WIDTH   = 32,
  parameter int unsigned  RESET_PC     = DefaultResetPc,
  parameter int unsigned  PC_STEP      = DefaultPcStep,
  parameter int unsigned  QUEUE_DEPTH  = 4,
  localparam int unsigned CountW       = count_width(QUEUE_DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    next_PC_select,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]   imem_rdata,
  fetch_prefetch_if.master        dec,
  output logic [ADDRESS_BITS-1:0] PC,
  output logic [CountW-1:0]       count
);

  localparam int unsigned       EntryW = DATA_WIDTH + ADDRESS_BITS;
  localparam logic [CountW:0]   DepthC = (CountW + 1)'(QUEUE_DEPTH);

  logic [ADDRESS_BITS-1:0] pc_q;
  logic [ADDRESS_BITS-1:0] inflight_pc_q;
  logic                    inflight_q;
  logic                    kill;
  logic                    push;
  logic                    pop;
  logic                    inst_valid;
  logic [CountW:0]         credit;
  logic [EntryW-1:0]       head;

  // A redirect discards whatever read returns this cycle.
  assign kill = next_PC_select;

  // The outstanding read already owns a queue slot, so the queue can never overflow.
  assign credit   = {1'b0, count} + {{CountW{1'b0}}, inflight_q};
  assign imem_req = !reset && !next_PC_select && (credit < DepthC);

  assign imem_addr = pc_q;
  assign PC        = pc_q;

  assign push       = inflight_q && !kill;
  assign inst_valid = (count != '0) && !next_PC_select;
  assign pop        = inst_valid && dec.inst_ready;

  assign dec.inst_valid = inst_valid;
  assign dec.inst       = head[EntryW-1:ADDRESS_BITS];
  assign dec.inst_PC    = head[ADDRESS_BITS-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= ADDRESS_BITS'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= imem_req;
      if (next_PC_select) begin
        pc_q <= target_PC;
      end else if (imem_req) begin
        pc_q          <= pc_q + ADDRESS_BITS'(PC_STEP);
        inflight_pc_q <= pc_q;
      end
    end
  end

  fetch_prefetch_fifo #(
    .WIDTH (EntryW),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (kill),
    .push      (push),
    .push_data ({imem_rdata, inflight_pc_q}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch. Memory returns addr ^ 32'hA5A5_0000
// one cycle after each request; expected PCs are queued by the bench when a
// reset or redirect is applied and compared as decode pops entries.
module tb_fetch_prefetch;

  logic        clock          = 1'b0;
  logic        reset          = 1'b1;
  logic        next_PC_select = 1'b0;
  logic [15:0] target_PC      = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata     = '0;
  logic [15:0] PC;
  logic [2:0]  count;

  int checks = 0;
  int passed = 0;
  logic [15:0] exp_q [$];

  fetch_prefetch_if #(.ADDRESS_BITS(16), .DATA_WIDTH(32)) dec_if ();

  fetch_prefetch #(
    .ADDRESS_BITS (16),
    .DATA_WIDTH   (32),
    .RESET_PC     (0),
    .PC_STEP      (4),
    .QUEUE_DEPTH  (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .next_PC_select (next_PC_select),
    .target_PC      (target_PC),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .dec            (dec_if),
    .PC             (PC),
    .count          (count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (imem_req) imem_rdata <= {16'h0000, imem_addr} ^ 32'hA5A5_0000;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] exp_inst(input logic [15:0] a);
    return {16'h0000, a} ^ 32'hA5A5_0000;
  endfunction

  task automatic push_seq(input logic [15:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 16'(4 * i));
  endtask

  // Returns at the negedge where reset is released (start of C0).
  task automatic apply_reset(input logic rdy);
    @(negedge clock);
    reset             = 1'b1;
    next_PC_select    = 1'b0;
    target_PC         = '0;
    dec_if.inst_ready = rdy;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (PC !== 16'h0000) $display("FAIL reset_pc: got %h expected 0000", PC);
    else passed++;
    checks++;
    if (imem_addr !== 16'h0000) $display("FAIL reset_addr: got %h expected 0000", imem_addr);
    else passed++;
    checks++;
    if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req);
    else passed++;
    checks++;
    if (dec_if.inst_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dec_if.inst_valid);
    else passed++;
    checks++;
    if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count);
    else passed++;
    checks++;
    if (dec_if.inst !== 32'h0 || dec_if.inst_PC !== 16'h0)
      $display("FAIL reset_head: got %h/%h expected 0/0", dec_if.inst, dec_if.inst_PC);
    else passed++;
  endtask

  task automatic test_sequential();
    logic [15:0] e;
    int pops = 0;
    apply_reset(1'b1);
    push_seq(16'h0000, 10);
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(4 * cyc))
        $display("FAIL seq_req C%0d: got req=%b addr=%h expected req=1 addr=%h",
                 cyc, imem_req, imem_addr, 16'(4 * cyc));
      else passed++;
      if (cyc < 2) begin
        checks++;
        if (dec_if.inst_valid !== 1'b0)
          $display("FAIL seq_early_valid C%0d: got %b expected 0", cyc, dec_if.inst_valid);
        else passed++;
      end
      if (cyc == 2) begin
        checks++;
        if (dec_if.inst_valid !== 1'b1)
          $display("FAIL seq_first_valid: got %b expected 1", dec_if.inst_valid);
        else passed++;
      end
      if (dec_if.inst_valid && dec_if.inst_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        pops++;
        checks++;
        if (dec_if.inst_PC !== e || dec_if.inst !== exp_inst(e))
          $display("FAIL seq_pop: got %h/%h expected %h/%h",
                   dec_if.inst_PC, dec_if.inst, e, exp_inst(e));
        else passed++;
      end
      @(negedge clock);
    end
    checks++;
    if (pops !== 10) $display("FAIL seq_throughput: got %0d pops expected 10", pops);
    else passed++;
  endtask

  task automatic test_stall();
    logic [15:0] e;
    int reqs = 0;
    apply_reset(1'b0);
    push_seq(16'h0000, 6);
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      if (imem_req) reqs++;
      @(negedge clock);
    end
    #1;
    checks++;
    if (count !== 3'd4) $display("FAIL stall_count: got %0d expected 4", count);
    else passed++;
    checks++;
    if (imem_req !== 1'b0 || reqs !== 4)
      $display("FAIL stall_req: got req=%b total=%0d expected req=0 total=4", imem_req, reqs);
    else passed++;
    dec_if.inst_ready = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) $display("FAIL stall_ready_path: got %b expected 0", imem_req);
    else passed++;
    e = exp_q.pop_front();
    checks++;
    if (dec_if.inst_valid !== 1'b1 || dec_if.inst_PC !== e || dec_if.inst !== exp_inst(e))
      $display("FAIL stall_head: got %b/%h/%h expected 1/%h/%h",
               dec_if.inst_valid, dec_if.inst_PC, dec_if.inst, e, exp_inst(e));
    else passed++;
    @(negedge clock);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0010)
      $display("FAIL stall_resume: got req=%b addr=%h expected req=1 addr=0010",
               imem_req, imem_addr);
    else passed++;
    for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
      if (dec_if.inst_valid && dec_if.inst_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (dec_if.inst_PC !== e || dec_if.inst !== exp_inst(e))
          $display("FAIL stall_drain: got %h/%h expected %h/%h",
                   dec_if.inst_PC, dec_if.inst, e, exp_inst(e));
        else passed++;
      end
      @(negedge clock);
      #1;
    end
    checks++;
    if (exp_q.size() !== 0) $display("FAIL stall_timeout: got %0d left expected 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_redirect();
    logic [15:0] e;
    apply_reset(1'b0);
    repeat (4) @(negedge clock);
    // C4: three entries queued and the read of 0x000C in flight.
    next_PC_select = 1'b1;
    target_PC      = 16'h0010;
    #1;
    checks++;
    if (count !== 3'd3 || imem_req !== 1'b0 || dec_if.inst_valid !== 1'b0)
      $display("FAIL redir_cycle: got count=%0d req=%b valid=%b expected 3/0/0",
               count, imem_req, dec_if.inst_valid);
    else passed++;
    push_seq(16'h0010, 4);
    @(negedge clock);
    next_PC_select    = 1'b0;
    dec_if.inst_ready = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 16'h0010)
      $display("FAIL redir_after: got count=%0d req=%b addr=%h expected 0/1/0010",
               count, imem_req, imem_addr);
    else passed++;
    for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
      if (dec_if.inst_valid && dec_if.inst_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (dec_if.inst_PC !== e || dec_if.inst !== exp_inst(e))
          $display("FAIL redir_drain: got %h/%h expected %h/%h",
                   dec_if.inst_PC, dec_if.inst, e, exp_inst(e));
        else passed++;
      end
      @(negedge clock);
      #1;
    end
    checks++;
    if (exp_q.size() !== 0) $display("FAIL redir_timeout: got %0d left expected 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_back_to_back_redirect();
    logic [15:0] e;
    apply_reset(1'b1);
    repeat (3) @(negedge clock);
    next_PC_select = 1'b1;
    target_PC      = 16'h0020;
    #1;
    @(negedge clock);
    target_PC = 16'h0040;
    #1;
    checks++;
    if (count !== 3'd0 || imem_req !== 1'b0)
      $display("FAIL b2b_second: got count=%0d req=%b expected 0/0", count, imem_req);
    else passed++;
    push_seq(16'h0040, 4);
    @(negedge clock);
    next_PC_select = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || PC !== 16'h0040)
      $display("FAIL b2b_req: got req=%b addr=%h pc=%h expected 1/0040/0040",
               imem_req, imem_addr, PC);
    else passed++;
    for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
      if (dec_if.inst_valid && dec_if.inst_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (dec_if.inst_PC !== e || dec_if.inst !== exp_inst(e))
          $display("FAIL b2b_drain: got %h/%h expected %h/%h",
                   dec_if.inst_PC, dec_if.inst, e, exp_inst(e));
        else passed++;
      end
      @(negedge clock);
      #1;
    end
    checks++;
    if (exp_q.size() !== 0) $display("FAIL b2b_timeout: got %0d left expected 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    apply_reset(1'b1);
    repeat (2) @(negedge clock);
    next_PC_select = 1'b1;
    target_PC      = 16'hFFFC;
    #1;
    push_seq(16'hFFFC, 3);
    @(negedge clock);
    next_PC_select = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 16'hFFFC) $display("FAIL wrap_first: got %h expected fffc", imem_addr);
    else passed++;
    @(negedge clock);
    #1;
    checks++;
    if (imem_addr !== 16'h0000 || PC !== 16'h0000)
      $display("FAIL wrap_next: got addr=%h pc=%h expected 0000/0000", imem_addr, PC);
    else passed++;
    for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
      if (dec_if.inst_valid && dec_if.inst_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (dec_if.inst_PC !== e || dec_if.inst !== exp_inst(e))
          $display("FAIL wrap_drain: got %h/%h expected %h/%h",
                   dec_if.inst_PC, dec_if.inst, e, exp_inst(e));
        else passed++;
      end
      @(negedge clock);
      #1;
    end
    checks++;
    if (exp_q.size() !== 0) $display("FAIL wrap_timeout: got %0d left expected 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    apply_reset(1'b1);
    repeat (5) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (PC !== 16'h0000 || imem_addr !== 16'h0000 || imem_req !== 1'b0)
      $display("FAIL areset_pc: got pc=%h addr=%h req=%b expected 0000/0000/0",
               PC, imem_addr, imem_req);
    else passed++;
    checks++;
    if (dec_if.inst_valid !== 1'b0 || count !== 3'd0)
      $display("FAIL areset_queue: got valid=%b count=%0d expected 0/0", dec_if.inst_valid, count);
    else passed++;
    checks++;
    if (dec_if.inst !== 32'h0 || dec_if.inst_PC !== 16'h0)
      $display("FAIL areset_head: got %h/%h expected 0/0", dec_if.inst, dec_if.inst_PC);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    push_seq(16'h0000, 3);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
      $display("FAIL areset_restart: got req=%b addr=%h expected 1/0000", imem_req, imem_addr);
    else passed++;
    for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
      if (dec_if.inst_valid && dec_if.inst_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (dec_if.inst_PC !== e || dec_if.inst !== exp_inst(e))
          $display("FAIL areset_drain: got %h/%h expected %h/%h",
                   dec_if.inst_PC, dec_if.inst, e, exp_inst(e));
        else passed++;
      end
      @(negedge clock);
      #1;
    end
    checks++;
    if (exp_q.size() !== 0) $display("FAIL areset_timeout: got %0d left expected 0", exp_q.size());
    else passed++;
  endtask

  initial begin
    dec_if.inst_ready = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_back_to_back_redirect();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
